// File: rtl/systolic_array_os.sv
// Output-stationary INT8 GEMM tile engine.
// A columns stream in from the left and B rows from the top. Both are skewed
// so that beat t meets PE(i,j) at edge t+1+i+j. Each PE keeps its own C
// element. A finished tile is copied into a result bank in one edge, which
// frees the array for the next tile while the bank drains one row at a time.

// Per-lane delay line, DEPTH >= 1 stages, cleared on reset.
module systolic_array_os_dly #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

  // shift one stage per clock; stage 0 takes the new input
  always_comb begin
    sr_d    = '0;
    sr_d[0] = d;
    for (int n = 1; n < DEPTH; n++) sr_d[n] = sr_q[n-1];
  end

  // delay-line storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q[DEPTH-1];
endmodule

// One processing element: MAC into a local accumulator, and forward a (with
// its valid bit) to the right and b downward, one register each.
module systolic_array_os_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              v_i,
  input  logic [ACC_W-1:0]  a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              v_o,
  output logic [ACC_W-1:0]  a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);
  logic              v_q, v_d;
  logic [ACC_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  prod;

  // a already carries the offset; product wraps at ACC_W bits
  assign prod = $signed(a_i) * ACC_W'($signed(b_i));

  // forward operands; clear on bank copy, otherwise accumulate valid beats
  always_comb begin
    v_d   = v_i;
    a_d   = a_i;
    b_d   = b_i;
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (v_i) acc_d = acc_q + prod;
  end

  // PE registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      v_q   <= v_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign v_o   = v_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
endmodule

module systolic_array_os #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ACC_W-1:0]                     input_offset,
  input  logic [K_W-1:0]                       k,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_W*ROWS-1:0]               A,
  input  logic [DATA_W*COLS-1:0]               B,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] out_row,
  output logic                                 out_last,
  output logic [ACC_W*COLS-1:0]                C,
  output logic                                 busy
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FC_W  = $clog2(ROWS + COLS);
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(ROWS + COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_HOLD} state_t;

  state_t                                 state_q, state_d;
  logic [K_W-1:0]                         k_lat_q, k_lat_d;
  logic [K_W-1:0]                         beat_cnt_q, beat_cnt_d;
  logic [FC_W-1:0]                        flush_cnt_q, flush_cnt_d;
  logic                                   live_q, live_d;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   bank_q, bank_d;
  logic                                   bank_full_q, bank_full_d;
  logic [ROW_W-1:0]                       out_row_q, out_row_d;

  logic accept, pop, pop_last, bank_free, copy;

  // systolic wiring: a/valid flow right, b flows down
  logic [ROWS-1:0][COLS:0][ACC_W-1:0]     a_h;
  logic [ROWS-1:0][COLS:0]                v_h;
  logic [ROWS:0][COLS-1:0][DATA_W-1:0]    b_v;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   acc;

  // in_ready is held low until the first edge after reset releases
  assign in_ready = live_q && (((state_q == S_IDLE) && (k != '0)) || (state_q == S_LOAD));
  assign accept   = in_valid && in_ready;

  assign pop       = bank_full_q && out_ready;
  assign pop_last  = pop && (out_row_q == ROW_LAST);
  // the bank counts as free on the edge its last row leaves
  assign bank_free = !bank_full_q || pop_last;

  genvar i, j;
  generate
    for (i = 0; i < ROWS; i++) begin : g_a_skew
      logic [ACC_W-1:0] a_lane;
      logic [ACC_W:0]   a_sk;
      assign a_lane = ACC_W'($signed(A[(ROWS-1-i)*DATA_W +: DATA_W])) + input_offset;
      systolic_array_os_dly #(.W(ACC_W + 1), .DEPTH(i + 1)) u_dly (
        .clk(clk), .rst(rst), .d({accept, a_lane}), .q(a_sk)
      );
      assign {v_h[i][0], a_h[i][0]} = a_sk;
    end

    for (j = 0; j < COLS; j++) begin : g_b_skew
      systolic_array_os_dly #(.W(DATA_W), .DEPTH(j + 1)) u_dly (
        .clk(clk), .rst(rst), .d(B[(COLS-1-j)*DATA_W +: DATA_W]), .q(b_v[0][j])
      );
    end

    for (i = 0; i < ROWS; i++) begin : g_row
      for (j = 0; j < COLS; j++) begin : g_col
        systolic_array_os_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
          .clk  (clk),
          .rst  (rst),
          .clr  (copy),
          .v_i  (v_h[i][j]),
          .a_i  (a_h[i][j]),
          .b_i  (b_v[i][j]),
          .v_o  (v_h[i][j+1]),
          .a_o  (a_h[i][j+1]),
          .b_o  (b_v[i+1][j]),
          .acc_o(acc[i][j])
        );
      end
    end
  endgenerate

  // forwarding outputs at the right and bottom edges have no consumer
  logic unused_edge;
  always_comb begin
    unused_edge = ^b_v[ROWS];
    for (int r = 0; r < ROWS; r++) unused_edge = unused_edge ^ v_h[r][COLS] ^ (^a_h[r][COLS]);
  end

  // tile FSM: count beats, wait for the skew to empty, hand off to the bank
  always_comb begin
    state_d     = state_q;
    k_lat_d     = k_lat_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    copy        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          k_lat_d     = k;
          beat_cnt_d  = K_W'(1);
          flush_cnt_d = '0;
          state_d     = (k == K_W'(1)) ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + K_W'(1);
          if (beat_cnt_q + K_W'(1) == k_lat_q) begin
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q != FLUSH_LAST) begin
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end else if (bank_free) begin
          copy    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bank_free) begin
          copy    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // result bank and row-serial drain; a copy overrides the last-row release
  always_comb begin
    live_d      = 1'b1;
    bank_d      = bank_q;
    bank_full_d = bank_full_q;
    out_row_d   = out_row_q;
    if (pop)      out_row_d   = pop_last ? '0 : out_row_q + ROW_W'(1);
    if (pop_last) bank_full_d = 1'b0;
    if (copy) begin
      bank_d      = acc;
      bank_full_d = 1'b1;
    end
  end

  // control and bank registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_lat_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      live_q      <= 1'b0;
      bank_q      <= '0;
      bank_full_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_lat_q     <= k_lat_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      live_q      <= live_d;
      bank_q      <= bank_d;
      bank_full_q <= bank_full_d;
      out_row_q   <= out_row_d;
    end
  end

  assign out_valid = bank_full_q;
  assign out_row   = out_row_q;
  assign out_last  = bank_full_q && (out_row_q == ROW_LAST);
  assign C         = bank_full_q ? bank_q[out_row_q] : '0;
  assign busy      = (state_q != S_IDLE) || bank_full_q;
endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: a table of tiles driven through a 4x4 engine
// with a model-fed row scoreboard, plus hand sequences for bubbles,
// backpressure/HOLD, mid-flush reset and a 2x8 geometry.
module tb_systolic_array_os;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4x4 engine
  logic [31:0]        input_offset;
  logic [7:0]         k;
  logic               in_valid, in_ready;
  logic [ROWS*8-1:0]  A;
  logic [COLS*8-1:0]  B;
  logic               out_valid, out_ready, out_last, busy;
  logic [1:0]         out_row;
  logic [COLS*32-1:0] C;

  // 2x8 engine
  logic [31:0]  off2;
  logic [7:0]   k2;
  logic         in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
  logic [15:0]  A2;
  logic [63:0]  B2;
  logic [0:0]   out_row2;
  logic [255:0] C2;

  systolic_array_os #(.DATA_W(8), .ACC_W(32), .ROWS(ROWS), .COLS(COLS), .K_W(8)) u_dut (
    .clk(clk), .rst(rst), .input_offset(input_offset), .k(k),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .C(C), .busy(busy)
  );

  systolic_array_os #(.DATA_W(8), .ACC_W(32), .ROWS(2), .COLS(8), .K_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .input_offset(off2), .k(k2),
    .in_valid(in_valid2), .in_ready(in_ready2), .A(A2), .B(B2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_row(out_row2),
    .out_last(out_last2), .C(C2), .busy(busy2)
  );

  typedef struct {
    int                    k;
    logic [31:0]           off;
    logic [ROWS-1:0][7:0]  a0;   // lane i value on beat 0
    logic [COLS-1:0][7:0]  b0;
    logic [7:0]            da;   // per-beat increment of every A lane
    logic [7:0]            db;
  } tile_t;

  typedef struct {
    int                    row;
    logic                  last;
    logic [COLS-1:0][31:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic tile_t mk(input int kk, input logic [31:0] off,
                               input logic [ROWS-1:0][7:0] a0, input logic [COLS-1:0][7:0] b0,
                               input logic [7:0] da, input logic [7:0] db);
    tile_t t;
    t.k = kk; t.off = off; t.a0 = a0; t.b0 = b0; t.da = da; t.db = db;
    return t;
  endfunction

  function automatic logic [ROWS*8-1:0] beat_a(input tile_t t, input int n);
    logic [ROWS*8-1:0] r;
    r = '0;
    for (int i = 0; i < ROWS; i++) r[(ROWS-1-i)*8 +: 8] = t.a0[i] + 8'(n) * t.da;
    return r;
  endfunction

  function automatic logic [COLS*8-1:0] beat_b(input tile_t t, input int n);
    logic [COLS*8-1:0] r;
    r = '0;
    for (int j = 0; j < COLS; j++) r[(COLS-1-j)*8 +: 8] = t.b0[j] + 8'(n) * t.db;
    return r;
  endfunction

  // reference GEMM: sum over beats of (a+off)*b, modulo 2^32
  function automatic void push_tile(input tile_t t);
    logic [ROWS-1:0][COLS-1:0][31:0] acc;
    logic [7:0] av, bv;
    exp_t e;
    acc = '0;
    for (int n = 0; n < t.k; n++)
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          av = t.a0[i] + 8'(n) * t.da;
          bv = t.b0[j] + 8'(n) * t.db;
          acc[i][j] = acc[i][j] + (32'(signed'(av)) + t.off) * 32'(signed'(bv));
        end
    for (int i = 0; i < ROWS; i++) begin
      e.row  = i;
      e.last = (i == ROWS - 1);
      e.c    = acc[i];
      exp_q.push_back(e);
    end
  endfunction

  // scoreboard: every row handed over must match the head of the queue
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_row", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("C_row", C, e.c);
        check("out_row", out_row, e.row);
        check("out_last", out_last, e.last);
      end
    end
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic send_beat(input logic [ROWS*8-1:0] a, input logic [COLS*8-1:0] b, output int t_acc);
    int n;
    n = 0;
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    check("beat_accept", in_ready, 1);
    t_acc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_rise(input int t_last);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 600) begin n++; @(negedge clk); end
    check("out_valid_rise_edge", cyc, t_last + ROWS + COLS);
    @(posedge clk); #1;
  endtask

  task automatic run_tile(input tile_t t, input bit gap, input bit lat);
    int tl;
    k = 8'(t.k);
    input_offset = t.off;
    for (int n = 0; n < t.k; n++) begin
      send_beat(beat_a(t, n), beat_b(t, n), tl);
      if (gap && n < t.k - 1) begin @(posedge clk); #1; end
    end
    push_tile(t);
    if (lat) wait_rise(tl);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 3000) begin n++; @(negedge clk); end
    check("drain_done", {exp_q.size() == 0, busy}, 2'b10);
    @(posedge clk); #1;
  endtask

  initial begin
    tile_t        tbl[6];
    int           gaps, seen, tl, n;
    logic [255:0] e0, e1;

    in_valid = 0; A = '0; B = '0; k = 8'd8; input_offset = '0; out_ready = 1'b1;
    off2 = '0; k2 = '0; in_valid2 = 0; A2 = '0; B2 = '0; out_ready2 = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_last", out_last, 0);
    check("rst_C", C, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // tile table: distinct operand patterns, wrap, k=1 and k=255 bounds
    tbl[0] = mk(8, 32'd0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd0, 8'd0);
    tbl[1] = mk(8, -32'sd128, {4{8'h80}}, {4{8'h7f}}, 8'd0, 8'd0);
    tbl[2] = mk(5, 32'd3, {8'h80, 8'd100, 8'd7, 8'hfb}, {8'hff, 8'd127, 8'hfd, 8'd2}, 8'd1, 8'hfe);
    tbl[3] = mk(1, -32'sd1000, {8'd50, 8'hff, 8'd1, 8'd0}, {8'd0, 8'd5, 8'd127, 8'h80}, 8'd0, 8'd0);
    tbl[4] = mk(3, 32'h7fffffff, {4{8'd1}}, {8'hff, 8'd3, 8'd2, 8'd1}, 8'd0, 8'd0);
    tbl[5] = mk(255, 32'd0, {8'd9, 8'hc3, 8'd77, 8'h11}, {8'h5a, 8'he0, 8'd3, 8'h81}, 8'd1, 8'd3);
    for (int t = 0; t < 6; t++) begin
      run_tile(tbl[t], 1'b0, 1'b1);
      wait_drain();
    end

    // bubbles between beats add nothing
    run_tile(mk(3, 32'd0, {4{8'd1}}, {4{8'd1}}, 8'd0, 8'd0), 1'b1, 1'b1);
    wait_drain();

    // backpressure: second tile parks in HOLD until the bank empties
    out_ready = 1'b0;
    run_tile(mk(4, 32'd0, {4{8'd1}}, {4{8'd1}}, 8'd0, 8'd0), 1'b0, 1'b0);
    run_tile(mk(4, 32'd0, {4{8'd2}}, {4{8'd2}}, 8'd0, 8'd0), 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("hold_in_ready", in_ready, 0);
    check("hold_busy", busy, 1);
    check("hold_out_valid", out_valid, 1);
    check("hold_out_row", out_row, 0);
    check("hold_C_stable", C, exp_q[0].c);
    @(posedge clk); #1;
    out_ready = 1'b1;
    gaps = 0;
    repeat (8) begin @(negedge clk); if (!out_valid) gaps++; end
    check("no_bubble_between_tiles", gaps, 0);
    @(posedge clk); #1;
    wait_drain();

    // reset during FLUSH discards the tile
    k = 8'd8; input_offset = '0;
    for (int b = 0; b < 8; b++) send_beat({4{8'd1}}, {4{8'd1}}, tl);
    repeat (3) @(negedge clk);
    check("flush_busy", busy, 1);
    rst = 1'b1; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen++; end
    check("no_out_after_rst", seen, 0);
    @(posedge clk); #1;
    run_tile(mk(1, 32'd0, {4{8'd1}}, {4{8'd1}}, 8'd0, 8'd0), 1'b0, 1'b1);
    wait_drain();

    // 2x8 geometry, k=0 never accepted, then a k=1 tile
    A2 = {8'd3, 8'hff};
    for (int j = 0; j < 8; j++) B2[(7-j)*8 +: 8] = 8'(j);
    in_valid2 = 1'b1;
    repeat (3) begin @(negedge clk); check("k0_in_ready", in_ready2, 0); end
    @(posedge clk); #1;
    k2 = 8'd1;
    @(negedge clk);
    check("d2_accept", in_ready2, 1);
    tl = cyc + 1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid2 && n < 100) begin n++; @(negedge clk); end
    check("d2_rise_edge", cyc, tl + 10);
    e0 = '0; e1 = '0;
    for (int j = 0; j < 8; j++) begin
      e0[j*32 +: 32] = 32'(3 * j);
      e1[j*32 +: 32] = -32'(j);
    end
    check("d2_row0_C", C2, e0);
    check("d2_row0_idx", out_row2, 0);
    check("d2_row0_last", out_last2, 0);
    @(negedge clk);
    check("d2_row1_C", C2, e1);
    check("d2_row1_idx", out_row2, 1);
    check("d2_row1_last", out_last2, 1);
    @(negedge clk);
    check("d2_done_valid", out_valid2, 0);
    check("d2_done_busy", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
